// File: rtl/bcd_tick_counter.sv
// Two-digit packed-BCD up/down counter clocked on the falling edge of clk.
// Counts one step per tick, wraps at MAX_BCD, and supports a validated load.
module bcd_tick_counter #(
  parameter logic [7:0] MAX_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       up_dn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry,
  output logic       borrow,
  output logic       load_err,
  output logic       zero
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       load_err_q, load_err_d;

  logic       load_ok;
  logic       at_max;
  logic       at_zero;

  // For well-formed BCD the binary order of the packed byte equals the numeric order.
  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                   (load_val <= MAX_BCD);
  assign at_max  = ({tens_q, ones_q} == MAX_BCD);
  assign at_zero = ({tens_q, ones_q} == 8'h00);

  always_comb begin
    ones_d     = ones_q;
    tens_d     = tens_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        {tens_d, ones_d} = load_val;
      end else begin
        {tens_d, ones_d} = 8'h00;
        load_err_d       = 1'b1;
      end
    end else if (tick) begin
      if (up_dn) begin
        if (at_max) begin
          {tens_d, ones_d} = 8'h00;
          carry_d          = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          {tens_d, ones_d} = MAX_BCD;
          borrow_d         = 1'b1;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign ones     = ones_q;
  assign tens     = tens_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;
  assign zero     = at_zero;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench: two counters (MAX_BCD 99 and 59) against a decimal reference
// model, with expectations queued on each falling edge and checked on the rising edge.
module tb_bcd_tick_counter;

  logic       clk;
  logic       clear;
  logic       tick;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;

  logic [3:0] ones99, tens99, ones59, tens59;
  logic       carry99, borrow99, err99, zero99;
  logic       carry59, borrow59, err59, zero59;
  logic [11:0] act99, act59;

  typedef struct packed {
    logic [11:0] e99;
    logic [11:0] e59;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cnt  [2];
  int   maxd [2];
  bit   mc [2];
  bit   mb [2];
  bit   me [2];

  bcd_tick_counter dut99 (
    .clk(clk), .clear(clear), .tick(tick), .up_dn(up_dn), .load(load),
    .load_val(load_val), .ones(ones99), .tens(tens99), .carry(carry99),
    .borrow(borrow99), .load_err(err99), .zero(zero99)
  );

  bcd_tick_counter #(.MAX_BCD(8'h59)) dut59 (
    .clk(clk), .clear(clear), .tick(tick), .up_dn(up_dn), .load(load),
    .load_val(load_val), .ones(ones59), .tens(tens59), .carry(carry59),
    .borrow(borrow59), .load_err(err59), .zero(zero59)
  );

  assign act99 = {tens99, ones99, carry99, borrow99, err99, zero99};
  assign act59 = {tens59, ones59, carry59, borrow59, err59, zero59};

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [11:0] exp_vec(input int v, input bit c, input bit b, input bit e);
    logic [7:0] bcd;
    bcd[7:4] = 4'(v / 10);
    bcd[3:0] = 4'(v % 10);
    return {bcd, c, b, e, (v == 0)};
  endfunction

  // Decimal reference of one falling edge for both counters.
  task automatic model_edge(input bit tk, input bit up, input bit ld, input logic [7:0] val);
    exp_t y;
    int   dec;
    for (int d = 0; d < 2; d++) begin
      mc[d] = 1'b0;
      mb[d] = 1'b0;
      me[d] = 1'b0;
      dec = int'(val[7:4]) * 10 + int'(val[3:0]);
      if (!clear) begin
        cnt[d] = 0;
      end else if (ld) begin
        if (val[7:4] <= 4'd9 && val[3:0] <= 4'd9 && dec <= maxd[d]) begin
          cnt[d] = dec;
        end else begin
          cnt[d] = 0;
          me[d]  = 1'b1;
        end
      end else if (tk) begin
        if (up) begin
          if (cnt[d] == maxd[d]) begin
            cnt[d] = 0;
            mc[d]  = 1'b1;
          end else begin
            cnt[d] = cnt[d] + 1;
          end
        end else begin
          if (cnt[d] == 0) begin
            cnt[d] = maxd[d];
            mb[d]  = 1'b1;
          end else begin
            cnt[d] = cnt[d] - 1;
          end
        end
      end
    end
    y.e99 = exp_vec(cnt[0], mc[0], mb[0], me[0]);
    y.e59 = exp_vec(cnt[1], mc[1], mb[1], me[1]);
    sb.push_back(y);
  endtask

  task automatic drive(input bit tk, input bit up, input bit ld, input logic [7:0] val);
    tick     = tk;
    up_dn    = up;
    load     = ld;
    load_val = val;
    @(negedge clk);
    model_edge(tk, up, ld, val);
    @(posedge clk);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) cnt[d] = 0;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    @(negedge clk);
    @(posedge clk);
    model_reset();
    clear = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (act99 !== 12'h001 || act59 !== 12'h001) begin
      n_fails++;
      $display("FAIL reset_state: got %h/%h expected 001/001", act99, act59);
    end
    @(posedge clk);
    // Ticks and loads while clear is low must be ignored.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, (i == 1), 8'h47);
      x = sb.pop_front();
      n_checks++;
      if (act99 !== x.e99 || act59 !== x.e59) begin
        n_fails++;
        $display("FAIL reset_hold step %0d: got %h/%h expected %h/%h",
                 i, act99, act59, x.e99, x.e59);
      end
    end
    clear = 1'b1;
  endtask

  task automatic test_up_wrap();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      x = sb.pop_front();
      n_checks++;
      if (act99 !== x.e99 || act59 !== x.e59) begin
        n_fails++;
        $display("FAIL up_wrap step %0d: got %h/%h expected %h/%h",
                 i, act99, act59, x.e99, x.e59);
      end
    end
    n_checks++;
    if ({tens99, ones99} !== 8'h00 || carry99 !== 1'b1) begin
      n_fails++;
      $display("FAIL up_wrap_final: got %h carry %b expected 00 carry 1",
               {tens99, ones99}, carry99);
    end
  endtask

  task automatic test_chain();
    do_reset();
    for (int i = 0; i < 160; i++) begin
      drive((i % 16) == 15, 1'b1, 1'b0, 8'h00);
      x = sb.pop_front();
      n_checks++;
      if (act99 !== x.e99 || act59 !== x.e59) begin
        n_fails++;
        $display("FAIL chain step %0d: got %h/%h expected %h/%h",
                 i, act99, act59, x.e99, x.e59);
      end
    end
    n_checks++;
    if ({tens99, ones99} !== 8'h10 || carry99 !== 1'b0) begin
      n_fails++;
      $display("FAIL chain_final: got %h carry %b expected 10 carry 0",
               {tens99, ones99}, carry99);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      x = sb.pop_front();
      n_checks++;
      if (act99 !== x.e99 || act59 !== x.e59) begin
        n_fails++;
        $display("FAIL down_wrap step %0d: got %h/%h expected %h/%h",
                 i, act99, act59, x.e99, x.e59);
      end
      if (i == 0) begin
        n_checks++;
        if ({tens59, ones59} !== 8'h59 || borrow59 !== 1'b1) begin
          n_fails++;
          $display("FAIL down_wrap_59: got %h borrow %b expected 59 borrow 1",
                   {tens59, ones59}, borrow59);
        end
      end
      if (i == 1) begin
        n_checks++;
        if ({tens59, ones59} !== 8'h58 || borrow59 !== 1'b0) begin
          n_fails++;
          $display("FAIL down_wrap_58: got %h borrow %b expected 58 borrow 0",
                   {tens59, ones59}, borrow59);
        end
      end
    end
  endtask

  task automatic test_load();
    logic [7:0] vals [8];
    bit         tks  [8];
    bit         lds  [8];
    vals = '{8'h47, 8'h4A, 8'h60, 8'h99, 8'h00, 8'h00, 8'hA3, 8'h10};
    tks  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    lds  = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tks[i], 1'b1, lds[i], vals[i]);
      x = sb.pop_front();
      n_checks++;
      if (act99 !== x.e99 || act59 !== x.e59) begin
        n_fails++;
        $display("FAIL load step %0d: got %h/%h expected %h/%h",
                 i, act99, act59, x.e99, x.e59);
      end
      if (i == 0) begin
        n_checks++;
        if ({tens99, ones99} !== 8'h47 || err99 !== 1'b0) begin
          n_fails++;
          $display("FAIL load_47: got %h err %b expected 47 err 0", {tens99, ones99}, err99);
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({tens59, ones59} !== 8'h00 || err59 !== 1'b1) begin
          n_fails++;
          $display("FAIL load_60_on_59: got %h err %b expected 00 err 1",
                   {tens59, ones59}, err59);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit up;
    up = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) up = ~up;
      drive($urandom_range(0, 3) != 0, up, $urandom_range(0, 15) == 0,
            8'($urandom_range(0, 255)));
      x = sb.pop_front();
      n_checks++;
      if (act99 !== x.e99 || act59 !== x.e59) begin
        n_fails++;
        $display("FAIL back_to_back step %0d: got %h/%h expected %h/%h",
                 i, act99, act59, x.e99, x.e59);
      end
    end
  endtask

  task automatic test_async_clear();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 8'h99);
    x = sb.pop_front();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    x = sb.pop_front();
    n_checks++;
    if (act99 !== x.e99 || carry99 !== 1'b1) begin
      n_fails++;
      $display("FAIL async_pre_carry: got %h expected %h", act99, x.e99);
    end
    tick = 1'b0;
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (act99 !== 12'h001 || act59 !== 12'h001) begin
      n_fails++;
      $display("FAIL async_cut_carry: got %h/%h expected 001/001", act99, act59);
    end
    @(posedge clk);
    model_reset();
    clear = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    x = sb.pop_front();
    n_checks++;
    if ({tens99, ones99} !== 8'h01 || act99 !== x.e99 || act59 !== x.e59) begin
      n_fails++;
      $display("FAIL async_first_tick: got %h/%h expected %h/%h",
               act99, act59, x.e99, x.e59);
    end
    drive(1'b0, 1'b1, 1'b1, 8'hAA);
    x = sb.pop_front();
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (err99 !== 1'b0 || err59 !== 1'b0 || zero99 !== 1'b1) begin
      n_fails++;
      $display("FAIL async_cut_err: got err %b/%b zero %b expected 0/0 zero 1",
               err99, err59, zero99);
    end
    @(posedge clk);
    model_reset();
    clear = 1'b1;
  endtask

  initial begin
    maxd[0]  = 99;
    maxd[1]  = 59;
    cnt[0]   = 0;
    cnt[1]   = 0;
    clear    = 1'b0;
    tick     = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    test_reset();
    test_up_wrap();
    test_chain();
    test_down_wrap();
    test_load();
    test_back_to_back();
    test_async_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
BCD_TICK_COUNTER -- requirements
Module: bcd_tick_counter

Interface
REQ-001 Parameter MAX_BCD, default 8'h99, is the terminal count as two packed BCD digits {tens, ones}; legal range 8'h01..8'h99 with each nibble 0-9.
REQ-002 CLK  input  1  single clock; all state changes on the falling edge.
REQ-003 CLEAR  input  1  reset, asynchronous, active-low.
REQ-004 TICK  input  1  count event from the upstream divide-by-N stage, synchronous to the falling edge of CLK, normally high for exactly one CLK period.
REQ-005 UP_DN  input  1  direction: 1 = count up, 0 = count down.
REQ-006 LOAD  input  1  synchronous load strobe.
REQ-007 LOAD_VAL  input  8  value for LOAD, packed BCD {tens[7:4], ones[3:0]}.
REQ-008 ONES  output  4  registered units digit, BCD.
REQ-009 TENS  output  4  registered tens digit, BCD.
REQ-010 CARRY  output  1  registered one-cycle pulse on up-count wrap MAX_BCD -> 00.
REQ-011 BORROW  output  1  registered one-cycle pulse on down-count wrap 00 -> MAX_BCD.
REQ-012 LOAD_ERR  output  1  registered one-cycle pulse on a rejected LOAD.
REQ-013 ZERO  output  1  high whenever {TENS, ONES} == 8'h00; decoded from the registers, no added latency.

Function
REQ-014 All registers SHALL update only on the falling edge of CLK, except for asynchronous reset.
REQ-015 Each falling edge SHALL evaluate, in priority order: LOAD, then TICK, then hold.
REQ-016 LOAD=1 with LOAD_VAL valid (each nibble <= 9 and LOAD_VAL <= MAX_BCD, compared numerically as BCD) SHALL set {TENS, ONES} = LOAD_VAL in that edge, and SHALL set LOAD_ERR=0.
REQ-017 LOAD=1 with LOAD_VAL invalid SHALL set {TENS, ONES} = 8'h00 and LOAD_ERR=1 for that one cycle.
REQ-018 LOAD=1 SHALL ignore a simultaneous TICK: no count, CARRY=0, BORROW=0.
REQ-019 LOAD=0, TICK=1, UP_DN=1 SHALL advance the count by one in BCD:
  - ONES 9 -> 0 with TENS+1;
  - otherwise ONES+1.
REQ-020 An up-count from exactly MAX_BCD SHALL give 8'h00 and CARRY=1 for one cycle.
REQ-021 LOAD=0, TICK=1, UP_DN=0 SHALL decrement by one in BCD:
  - ONES 0 -> 9 with TENS-1;
  - otherwise ONES-1.
REQ-022 A down-count from 8'h00 SHALL give MAX_BCD and BORROW=1 for one cycle.
REQ-023 CARRY, BORROW and LOAD_ERR SHALL be 0 on every edge not named in REQ-017, REQ-020 or REQ-022; they are never high simultaneously.
REQ-024 TICK held high for k consecutive falling edges SHALL produce k counts; the block SHALL NOT edge-detect TICK.
REQ-025 With MAX_BCD below 8'h99, counting up SHALL wrap at MAX_BCD (8'h59 wraps 59 -> 00), never passing through values above MAX_BCD.
REQ-026 {TENS, ONES} SHALL never hold a non-BCD nibble or a value above MAX_BCD.
REQ-027 An UP_DN change SHALL take effect on the next TICK with no lost or double count.

Reset
REQ-028 CLEAR=0 SHALL immediately, without a clock edge, force:
  - ONES=0, TENS=0;
  - CARRY=0, BORROW=0, LOAD_ERR=0;
  - ZERO=1.
REQ-029 While CLEAR=0 the block SHALL ignore TICK and LOAD.
REQ-030 After CLEAR rises, the first falling edge with TICK=1 SHALL give count 8'h01 (UP_DN=1).
REQ-031 CLEAR asserted mid-operation, including during a CARRY, BORROW or LOAD_ERR pulse, SHALL cut that pulse immediately.

Verification
REQ-032 Up wrap: MAX_BCD=8'h99, UP_DN=1, TICK high for 100 falling edges from reset -> count 00,01..09,10..99,00; CARRY=1 only in the cycle after the 99 -> 00 edge.
REQ-033 Upstream chaining: TICK driven by a divide-by-16 stage producing one-cycle pulses, 160 CLK falling edges -> count 8'h10, no CARRY.
REQ-034 Down wrap: MAX_BCD=8'h59, reset, UP_DN=0, one TICK -> count 8'h59 with BORROW=1 for one cycle; next TICK -> 8'h58 with BORROW=0.
REQ-035 Load rules:
  - LOAD_VAL=8'h47 with TICK=1 -> 8'h47, no count, LOAD_ERR=0;
  - LOAD_VAL=8'h4A -> 8'h00 with LOAD_ERR=1;
  - with MAX_BCD=8'h59, LOAD_VAL=8'h60 -> 8'h00 with LOAD_ERR=1.
REQ-036 Async reset: count 8'h99 with CARRY pending; drop CLEAR between clock edges -> ONES=TENS=0, CARRY=0, ZERO=1 before the next edge; the first TICK after release -> 8'h01.
